// File: rtl/mem_loader_pkg.sv
// Shared definitions for the boot loader, its memory array and the cpu top level.
package mem_loader_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } ld_state_e;
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read; a same-address write returns the old word.
module mem_array #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  // Read register holds when not enabled; only it is reset, contents are kept.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = ram[addr];
  end

  always_ff @(posedge clk) begin
    if (we) ram[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mem_loader.sv
// Unified program/data memory with a boot-load FSM that streams an image in before releasing the cpu.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LOAD_BASE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  cpu_run,
  output logic                  ld_err,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] mem
);
  localparam logic [ADDR_WIDTH:0] BASE = (ADDR_WIDTH+1)'(LOAD_BASE);

  ld_state_e             state_d, state_q;
  logic [ADDR_WIDTH:0]   ptr_d, ptr_q;
  logic [ADDR_WIDTH:0]   ptr_inc;
  logic                  hs;
  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  assign hs      = (state_q == ST_LOAD) && ld_valid;
  // Extra pointer bit makes running past the top of memory unambiguous.
  assign ptr_inc = ptr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: if (ld_start) begin
        state_d = ST_LOAD;
        ptr_d   = BASE;
      end
      ST_LOAD: if (hs) begin
        ptr_d = ptr_inc;
        if (ld_last)                  state_d = ST_RUN;
        else if (ptr_inc[ADDR_WIDTH]) state_d = ST_ERR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= BASE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Loader owns the array in LOAD, cpu owns it in RUN; otherwise it is idle.
  always_comb begin
    ram_re    = (state_q == ST_RUN);
    ram_we    = hs || (ram_re && we);
    ram_addr  = (state_q == ST_LOAD) ? ptr_q[ADDR_WIDTH-1:0] : addr;
    ram_wdata = (state_q == ST_LOAD) ? ld_data : data;
  end

  mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(mem)
  );

  assign ld_ready = (state_q == ST_LOAD);
  assign cpu_run  = (state_q == ST_RUN);
  assign ld_err   = (state_q == ST_ERR);
endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: model memory, expected read words queued at address drive.
module tb_mem_loader;
  logic        clk = 1'b0;
  logic        rst, ld_start, ld_valid, ld_last, we;
  logic [15:0] ld_data, data;
  logic [5:0]  addr;
  logic        ld_ready, cpu_run, ld_err;
  logic [15:0] mem;
  logic        ld_ready8, cpu_run8, ld_err8;
  logic [15:0] mem8;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] mdl [64];
  bit          mdl_v [64];
  int          mptr;
  logic [15:0] sb [$];

  always #5 clk = ~clk;

  mem_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .LOAD_BASE(0)) u_dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .cpu_run(cpu_run), .ld_err(ld_err),
    .addr(addr), .we(we), .data(data), .mem(mem)
  );

  mem_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .LOAD_BASE(8)) u_dut8 (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready8), .cpu_run(cpu_run8), .ld_err(ld_err8),
    .addr(addr), .we(we), .data(data), .mem(mem8)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; we = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_ready", ld_ready, 0);
    check("rst_run",   cpu_run,  0);
    check("rst_err",   ld_err,   0);
    check("rst_mem",   mem,      0);
  endtask

  task automatic start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    mptr = 0;
  endtask

  task automatic send(input logic [15:0] d, input bit last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    check("ld_ready", ld_ready, 1);
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    mdl[mptr] = d; mdl_v[mptr] = 1'b1; mptr++;
  endtask

  // Idle beat with junk on the data and last lines; must not be accepted.
  task automatic gap();
    ld_valid = 1'b0; ld_data = 16'($urandom); ld_last = 1'b1;
    tick();
    ld_last = 1'b0;
  endtask

  task automatic cpu_read(input logic [5:0] a);
    addr = a; we = 1'b0;
    sb.push_back(mdl[a]);
    tick();
    check($sformatf("rd[%0d]", a), mem, sb.pop_front());
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [15:0] d);
    bit had_old;
    had_old = mdl_v[a];
    addr = a; we = 1'b1; data = d;
    if (had_old) sb.push_back(mdl[a]);
    tick();
    we = 1'b0;
    if (had_old) check($sformatf("rdw_old[%0d]", a), mem, sb.pop_front());
    mdl[a] = d; mdl_v[a] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mdl_v[i] = 1'b0;
    addr = '0; data = '0; ld_data = '0;
    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; we = 1'b0;
    tick();

    // Basic 3-word image, then cpu reads with one-cycle latency.
    do_reset();
    start();
    send(16'h1111, 0); send(16'h2222, 0); send(16'h3333, 1);
    check("run_after_last", cpu_run, 1);
    check("ready_in_run", ld_ready, 0);
    for (int i = 0; i < 3; i++) cpu_read(6'(i));
    cpu_write(6'd3, 16'h0BAD);
    cpu_write(6'd5, 16'h00AA);
    cpu_write(6'd5, 16'h5555);
    cpu_read(6'd5);
    cpu_read(6'd3);

    // Gaps between valid words.
    do_reset();
    start();
    send(16'hA001, 0); gap(); gap(); send(16'hA002, 0); send(16'hA003, 1);
    check("gap_run", cpu_run, 1);
    for (int i = 0; i < 4; i++) cpu_read(6'(i));

    // Cpu port gated outside RUN.
    do_reset();
    addr = 6'd3; we = 1'b1; data = 16'hDEAD;
    tick(); tick();
    check("idle_mem", mem, 0);
    check("idle_ready", ld_ready, 0);
    start();
    send(16'hB001, 0); send(16'hB002, 1);
    we = 1'b0;
    check("gate_mem_pre", mem, 0);
    cpu_read(6'd3);
    cpu_read(6'd1);

    // Overflow without ld_last.
    do_reset();
    start();
    for (int i = 0; i < 64; i++) send(16'h4000 + 16'(i), 0);
    check("ovf_err", ld_err, 1);
    check("ovf_run", cpu_run, 0);
    check("ovf_ready", ld_ready, 0);
    start();
    check("ovf_restart_ready", ld_ready, 0);
    check("ovf_sticky", ld_err, 1);
    do_reset();
    start();
    send(16'h7777, 1);
    cpu_read(6'd63);
    cpu_read(6'd1);
    cpu_read(6'd0);

    // 64th word carrying ld_last runs rather than erroring.
    do_reset();
    start();
    for (int i = 0; i < 64; i++) send(16'h5000 + 16'(i), i == 63);
    check("full_run", cpu_run, 1);
    check("full_err", ld_err, 0);
    cpu_read(6'd63);
    cpu_read(6'd8);

    // Reset mid-load; partial image survives, restart begins at base.
    do_reset();
    start();
    send(16'hC001, 0); send(16'hC002, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_run", cpu_run, 0);
    check("mid_ready", ld_ready, 0);
    check("mid_mem", mem, 0);
    start();
    send(16'hD001, 1);
    check("base8_run", cpu_run8, 1);
    check("base8_err", ld_err8, 0);
    check("base8_ready", ld_ready8, 0);
    cpu_read(6'd0);
    cpu_read(6'd1);
    cpu_read(6'd8);
    check("base8_rd8", mem8, 16'hD001);
    cpu_read(6'd9);
    check("base8_rd9", mem8, 16'hC002);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
